line_window_gen: RTL and testbench

Parametrised K-row sliding-window generator for the binarised ResNet datapath. It generalises the fixed 3-row FIFO chain to K rows with on-chip line buffers, a selectable edge-padding mode and an internal bottom-edge flush. It takes one raster-ordered activation stream (SIZE × SIZE pixels, CHANNEL words per pixel) and emits three outputs:
- a column-aligned K-word window for the multiply stage;
- per-row sign codes for the compare stage;
- a delayed centre-row skip stream for the residual add.

---
 rtl/line_window_gen.sv | 229 ++++++++++++++++++++++
 tb/tb_line_window_gen.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/line_window_gen.sv
// line_window_gen
//   K-row sliding-window generator over a raster activation stream
//   (SIZE x SIZE pixels, CHANNEL words per pixel, row length L = SIZE*CHANNEL).
//   K-1 circular line buffers share the column address. The window is formed
//   from the live input word and the buffer read-outs, with zero or replicate
//   padding at the top and bottom edges. The bottom rows are emitted by an
//   internal flush after the last input word.
//
// Optional build macro: SIGN_OUT_EN adds the o_tdata_c port and the sign-code logic.
//
// Ports
//   i_sclk     clock, rising edge
//   i_rst      asynchronous active-high reset
//   i_vsync    frame start; clears counters, FSM -> FILL, clears o_err
//   i_valid    input word strobe (no backpressure)
//   i_tdata    input word
//   o_valid_m  window valid
//   o_hsync_m  first window word of each output row (col 0)
//   o_tdata_m  window, MSB slice = newest row, LSB slice = oldest row
//   o_tdata_c  2-bit sign code per window slice, same order (SIGN_OUT_EN)
//   o_valid_s  skip valid (o_valid_m delayed SKIP_DLY cycles)
//   o_tdata_s  centre slice of o_tdata_m delayed SKIP_DLY cycles
//   o_done     one-cycle pulse after the last window word of a frame
//   o_err      sticky: input arrived during FLUSH
module line_window_gen #(
    parameter int WIDTH_D  = 27,
    parameter int SIZE     = 28,
    parameter int CHANNEL  = 128,
    parameter int K        = 3,
    parameter int PAD_MODE = 1,
    parameter int SKIP_DLY = 10
) (
    input  logic                 i_sclk,
    input  logic                 i_rst,
    input  logic                 i_vsync,
    input  logic                 i_valid,
    input  logic [WIDTH_D-1:0]   i_tdata,
    output logic                 o_valid_m,
    output logic                 o_hsync_m,
    output logic [WIDTH_D*K-1:0] o_tdata_m,
`ifdef SIGN_OUT_EN
    output logic [2*K-1:0]       o_tdata_c,
`endif
    output logic                 o_valid_s,
    output logic [WIDTH_D-1:0]   o_tdata_s,
    output logic                 o_done,
    output logic                 o_err
);
    localparam int HALF  = (K - 1) / 2;
    localparam int L     = SIZE * CHANNEL;
    localparam int COL_W = (L > 1) ? $clog2(L) : 1;
    // Row counter runs on past SIZE-1 while flushing the bottom rows.
    localparam int ROW_W = $clog2(SIZE + HALF + 1);

    typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

    state_t                              state_q, state_d;
    logic [COL_W-1:0]                    col_q, col_d;
    logic [ROW_W-1:0]                    row_q, row_d;
    logic                                err_q, err_d;
    logic                                fin_q, fin_d;
    logic                                done_q, done_d;
    logic                                vm_q, vm_d;
    logic                                hs_q, hs_d;
    logic [K-1:0][WIDTH_D-1:0]           tm_q, tm_d;
    logic [SKIP_DLY-1:0]                 skip_vld_q, skip_vld_d;
    logic [SKIP_DLY-1:0][WIDTH_D-1:0]    skip_dat_q, skip_dat_d;
`ifdef SIGN_OUT_EN
    logic [K-1:0][1:0]                   tc_q, tc_d;
`endif

    logic                                adv;   // advance col/row and write buffers
    logic                                emit;  // produce a window word this cycle
    logic                                col_last;
    logic [K-1:0][WIDTH_D-1:0]           win;
    logic [WIDTH_D-1:0]                  rd    [K-1];
    logic [WIDTH_D-1:0]                  wdata [K-1];

    // Line buffers: buffer j holds the row j+1 above the current one.
    // Read-before-write at the shared column address shifts each row down one buffer.
    for (genvar j = 0; j < K - 1; j++) begin : g_lbuf
        logic [WIDTH_D-1:0] mem [L];
        assign rd[j] = mem[col_q];
        if (j == 0) begin : g_head
            assign wdata[j] = i_tdata;
        end else begin : g_chain
            assign wdata[j] = rd[j-1];
        end
        always_ff @(posedge i_sclk) begin
            if (adv) mem[col_q] <= wdata[j];
        end
    end

    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        row_d    = row_q;
        err_d    = err_q;
        fin_d    = 1'b0;
        adv      = 1'b0;
        emit     = 1'b0;
        col_last = (col_q == COL_W'(L - 1));
        if (i_vsync) begin
            state_d = FILL;
            col_d   = '0;
            row_d   = '0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: ;
                FILL: if (i_valid) begin
                    adv = 1'b1;
                    if (col_last && row_q == ROW_W'(HALF - 1)) state_d = RUN;
                end
                RUN: if (i_valid) begin
                    adv  = 1'b1;
                    emit = 1'b1;
                    if (col_last && row_q == ROW_W'(SIZE - 1)) state_d = FLUSH;
                end
                FLUSH: begin
                    adv  = 1'b1;
                    emit = 1'b1;
                    if (i_valid) err_d = 1'b1;
                    if (col_last && row_q == ROW_W'(SIZE + HALF - 1)) begin
                        state_d = IDLE;
                        fin_d   = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
            if (adv) begin
                if (col_last) begin
                    col_d = '0;
                    row_d = row_q + ROW_W'(1);
                end else begin
                    col_d = col_q + COL_W'(1);
                end
            end
        end
    end

    // Slice i sources row s = row-(K-1)+i. Out-of-range rows clamp to the
    // nearest valid row (or zero); depth d = row - clamped row picks the input
    // word (d=0) or line buffer d-1.
    always_comb begin
        for (int i = 0; i < K; i++) begin
            int s, sc, d;
            s  = int'(row_q) - (K - 1) + i;
            sc = (s < 0) ? 0 : ((s > SIZE - 1) ? SIZE - 1 : s);
            d  = int'(row_q) - sc;
            win[i] = '0;
            if (PAD_MODE != 0 || s == sc) begin
                if (d == 0) win[i] = i_tdata;
                for (int j = 0; j < K - 1; j++) begin
                    if (d == j + 1) win[i] = rd[j];
                end
            end
        end
    end

    always_comb begin
        vm_d   = emit;
        hs_d   = emit && (col_q == '0);
        tm_d   = emit ? win : tm_q;
        done_d = fin_q;
        skip_vld_d[0] = vm_q;
        skip_dat_d[0] = tm_q[HALF];
        for (int i = 1; i < SKIP_DLY; i++) begin
            skip_vld_d[i] = skip_vld_q[i-1];
            skip_dat_d[i] = skip_dat_q[i-1];
        end
`ifdef SIGN_OUT_EN
        tc_d = tc_q;
        if (emit) begin
            for (int i = 0; i < K; i++) begin
                if (win[i] == '0)                 tc_d[i] = 2'b00;
                else if (win[i][WIDTH_D-1])       tc_d[i] = 2'b11;
                else                              tc_d[i] = 2'b01;
            end
        end
`endif
    end

    always_ff @(posedge i_sclk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= IDLE;
            col_q      <= '0;
            row_q      <= '0;
            err_q      <= 1'b0;
            fin_q      <= 1'b0;
            done_q     <= 1'b0;
            vm_q       <= 1'b0;
            hs_q       <= 1'b0;
            tm_q       <= '0;
            skip_vld_q <= '0;
            skip_dat_q <= '0;
`ifdef SIGN_OUT_EN
            tc_q       <= '0;
`endif
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            err_q      <= err_d;
            fin_q      <= fin_d;
            done_q     <= done_d;
            vm_q       <= vm_d;
            hs_q       <= hs_d;
            tm_q       <= tm_d;
            skip_vld_q <= skip_vld_d;
            skip_dat_q <= skip_dat_d;
`ifdef SIGN_OUT_EN
            tc_q       <= tc_d;
`endif
        end
    end

    assign o_valid_m = vm_q;
    assign o_hsync_m = hs_q;
    assign o_tdata_m = tm_q;
`ifdef SIGN_OUT_EN
    assign o_tdata_c = tc_q;
`endif
    assign o_valid_s = skip_vld_q[SKIP_DLY-1];
    assign o_tdata_s = skip_dat_q[SKIP_DLY-1];
    assign o_done    = done_q;
    assign o_err     = err_q;

endmodule

// File: tb/tb_line_window_gen.sv
module tb_line_window_gen;
    localparam int W = 8, S = 4, C = 2, K = 3, HALF = 1, SD = 2;
    localparam int L = S * C;

    logic clk = 1'b0, rst = 1'b0, vsync = 1'b0, valid = 1'b0;
    logic [W-1:0] din = '0;
    always #5 clk = ~clk;

    logic           vm [2], hs [2], vs [2], dn [2], er [2];
    logic [W*K-1:0] tm [2];
    logic [W-1:0]   ts [2];
`ifdef SIGN_OUT_EN
    logic [2*K-1:0] tc [2];
`endif

    // Instance 0: zero padding, instance 1: replicate padding; same stimulus.
    for (genvar p = 0; p < 2; p++) begin : g_dut
        line_window_gen #(.WIDTH_D(W), .SIZE(S), .CHANNEL(C), .K(K),
                          .PAD_MODE(p), .SKIP_DLY(SD)) u_dut (
            .i_sclk(clk), .i_rst(rst), .i_vsync(vsync), .i_valid(valid), .i_tdata(din),
            .o_valid_m(vm[p]), .o_hsync_m(hs[p]), .o_tdata_m(tm[p]),
`ifdef SIGN_OUT_EN
            .o_tdata_c(tc[p]),
`endif
            .o_valid_s(vs[p]), .o_tdata_s(ts[p]), .o_done(dn[p]), .o_err(er[p]));
    end

    typedef struct { logic [W*K-1:0] w0, w1; logic hs; int cyc; } exp_t;
    typedef struct { logic [W-1:0] c0, c1; int cyc; } skp_t;

    exp_t wq [$];
    skp_t sq [$];
    int   dq [$];
    logic [W-1:0] img [S][L];
    int errs = 0, checks = 0, cyc = 0, nwin = 0, nsk = 0;
    logic [W*K-1:0] fw0, fw1, lw0, lw1;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Reference window centred on row rc, column c, straight from the padding rules.
    function automatic logic [W*K-1:0] mwin(int rc, int c, int pad);
        logic [W*K-1:0] r;
        r = '0;
        for (int i = 0; i < K; i++) begin
            int s;
            s = rc - HALF + i;
            if (s >= 0 && s < S)  r[i*W +: W] = img[s][c];
            else if (pad != 0)    r[i*W +: W] = img[(s < 0) ? 0 : S - 1][c];
        end
        return r;
    endfunction

    function automatic logic [2*K-1:0] sgn(logic [W*K-1:0] w);
        logic [2*K-1:0] r;
        for (int i = 0; i < K; i++) begin
            logic [W-1:0] v;
            v = w[i*W +: W];
            r[i*2 +: 2] = (v == '0) ? 2'b00 : (v[W-1] ? 2'b11 : 2'b01);
        end
        return r;
    endfunction

    // Monitor: pops expectations whenever the DUTs present output.
    always @(negedge clk) begin
        exp_t e;
        skp_t k;
        if (!rst) begin
            if (vm[0] || vm[1]) begin
                if (wq.size() == 0) chk("win_unexpected", {vm[1], vm[0]}, 0);
                else begin
                    e = wq.pop_front();
                    chk("win_valid", {vm[1], vm[0]}, 2'b11);
                    chk("win_pad0", tm[0], e.w0);
                    chk("win_pad1", tm[1], e.w1);
                    chk("win_hsync", {hs[1], hs[0]}, {2{e.hs}});
                    chk("win_cycle", cyc, e.cyc);
`ifdef SIGN_OUT_EN
                    chk("sign_pad0", tc[0], sgn(e.w0));
                    chk("sign_pad1", tc[1], sgn(e.w1));
`endif
                    if (nwin == 0) begin fw0 = tm[0]; fw1 = tm[1]; end
                    lw0 = tm[0]; lw1 = tm[1];
                    nwin++;
                end
            end else if (hs[0] || hs[1]) chk("hsync_no_valid", {hs[1], hs[0]}, 0);
            if (vs[0] || vs[1]) begin
                if (sq.size() == 0) chk("skip_unexpected", {vs[1], vs[0]}, 0);
                else begin
                    k = sq.pop_front();
                    chk("skip_valid", {vs[1], vs[0]}, 2'b11);
                    chk("skip_pad0", ts[0], k.c0);
                    chk("skip_pad1", ts[1], k.c1);
                    chk("skip_cycle", cyc, k.cyc);
                    nsk++;
                end
            end
            if (dn[0] || dn[1]) begin
                if (dq.size() == 0) chk("done_unexpected", {dn[1], dn[0]}, 0);
                else begin
                    chk("done_both", {dn[1], dn[0]}, 2'b11);
                    chk("done_cycle", cyc, dq.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive frame word n; push the window it completes (if any).
    task automatic put_word(int n, logic [W-1:0] v);
        int r, c;
        exp_t e;
        skp_t s;
        r = n / L;
        c = n % L;
        img[r][c] = v;
        valid = 1'b1;
        din = v;
        if (r >= HALF) begin
            e.w0 = mwin(r - HALF, c, 0);
            e.w1 = mwin(r - HALF, c, 1);
            e.hs = (c == 0);
            e.cyc = cyc + 1;
            wq.push_back(e);
            s.c0 = e.w0[HALF*W +: W];
            s.c1 = e.w1[HALF*W +: W];
            s.cyc = cyc + 1 + SD;
            sq.push_back(s);
        end
        tick();
        valid = 1'b0;
    endtask

    // mode 0: 1..N, mode 1: random, mode 2: sign pattern 80/05 with one 00.
    task automatic run_frame(int nw, int mode, bit inj);
        int nlast;
        logic [W-1:0] v;
        exp_t e;
        skp_t s;
        vsync = 1'b1; valid = 1'b1; din = 8'hEE;   // word coincident with vsync is dropped
        tick();
        vsync = 1'b0; valid = 1'b0;
        chk("err_cleared_pad0", er[0], 0);
        chk("err_cleared_pad1", er[1], 0);
        repeat (SD + 2) tick();
        nwin = 0; nsk = 0;
        nlast = 0;
        for (int n = 0; n < nw; n++) begin
            repeat ($urandom_range(0, 2)) tick();
            case (mode)
                0:       v = W'(n + 1);
                1:       v = W'($urandom);
                default: v = (n == 5) ? 8'h00 : ((n % 2 == 0) ? 8'h80 : 8'h05);
            endcase
            nlast = cyc;
            put_word(n, v);
        end
        if (nw == S * L) begin
            for (int k = 0; k < HALF * L; k++) begin
                e.w0 = mwin(S - HALF + k / L, k % L, 0);
                e.w1 = mwin(S - HALF + k / L, k % L, 1);
                e.hs = (k % L == 0);
                e.cyc = nlast + 2 + k;
                wq.push_back(e);
                s.c0 = e.w0[HALF*W +: W];
                s.c1 = e.w1[HALF*W +: W];
                s.cyc = e.cyc + SD;
                sq.push_back(s);
            end
            dq.push_back(nlast + 2 + HALF * L);
            for (int k = 0; k < HALF * L + SD + 4; k++) begin
                if (inj && k == 2) begin valid = 1'b1; din = W'($urandom); end
                tick();
                valid = 1'b0;
            end
            chk("err_pad0", er[0], 64'(inj));
            chk("err_pad1", er[1], 64'(inj));
            chk("frame_windows", nwin, S * L);
            chk("frame_skips", nsk, S * L);
            chk("win_queue_drained", wq.size(), 0);
            chk("skip_queue_drained", sq.size(), 0);
            chk("done_queue_drained", dq.size(), 0);
        end
    endtask

    task automatic check_ramp();
        chk("first_win_pad1", fw1, {8'd9, 8'd1, 8'd1});
        chk("first_win_pad0", fw0, {8'd9, 8'd1, 8'd0});
        chk("last_win_pad1", lw1, {8'd32, 8'd32, 8'd24});
        chk("last_win_pad0", lw0, {8'd0, 8'd32, 8'd24});
    endtask

    task automatic check_zero(string nm);
        for (int p = 0; p < 2; p++) begin
            chk({nm, "_valid_m"}, vm[p], 0);
            chk({nm, "_hsync"}, hs[p], 0);
            chk({nm, "_tdata_m"}, tm[p], 0);
            chk({nm, "_valid_s"}, vs[p], 0);
            chk({nm, "_tdata_s"}, ts[p], 0);
            chk({nm, "_done"}, dn[p], 0);
            chk({nm, "_err"}, er[p], 0);
`ifdef SIGN_OUT_EN
            chk({nm, "_tdata_c"}, tc[p], 0);
`endif
        end
    endtask

    initial begin
        #1 rst = 1'b1;
        #1 check_zero("reset");
        repeat (2) tick();
        rst = 1'b0;
        // Words before any vsync are ignored.
        for (int i = 0; i < 3; i++) begin
            valid = 1'b1; din = W'($urandom);
            tick();
        end
        valid = 1'b0;
        tick();
        run_frame(S * L, 0, 1'b0);
        check_ramp();
        run_frame(S * L, 1, 1'b1);          // input during FLUSH sets o_err
        run_frame(S * L, 0, 1'b0);          // vsync clears o_err, output repeats
        check_ramp();
        run_frame(S * L, 2, 1'b0);
        run_frame(13, 1, 1'b0);             // abandoned frame, restart mid-RUN
        run_frame(S * L, 1, 1'b0);
        run_frame(12, 1, 1'b0);             // reset mid-RUN
        rst = 1'b1;
        #1 check_zero("midreset");
        wq.delete(); sq.delete(); dq.delete();
        repeat (2) tick();
        rst = 1'b0;
        run_frame(S * L, 0, 1'b0);
        check_ramp();
        repeat (4) tick();
        chk("final_win_queue", wq.size(), 0);
        chk("final_skip_queue", sq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
